// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_types
// Description : Shared RV32I pipeline types and constants (fetch stage subset)
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    // Fetch-stage controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;   // addi x0,x0,0

endpackage
`default_nettype wire

// File: rtl/i_fetch.sv
`default_nettype none
// ============================================================================
// Module      : i_fetch
// Description : RV32I instruction-fetch stage. Owns the PC, runs the
//               instruction-memory request/response handshake and holds the
//               IF/ID pipeline register. Handles decode stalls and EX redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module i_fetch
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv32i_types::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  stale_q, stale_d;      // address of a request being discarded
    logic [31:0]  hold_q, hold_d;        // instruction parked while ID stalls
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;

    logic [31:0]  w_pc_plus4;

    assign w_pc_plus4 = pc_q + 32'd4;    // 32-bit modulo, wraps to 0

    // A discarded request keeps its original address until its response arrives
    assign imem_read    = (state_q == FETCH) || (state_q == DISCARD);
    assign imem_address = (state_q == DISCARD) ? stale_q : pc_q;

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;

    // Next-state logic: redirect outranks stall and response in every state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stale_d    = stale_q;
        hold_d     = hold_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        if (redirect) begin
            if_valid_d = 1'b0;
            pc_d       = redirect_pc;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    // Without a response the request is still in flight and
                    // must be finished at its old address, data thrown away.
                    if (!imem_resp) begin
                        stale_d = pc_q;
                        state_d = DISCARD;
                    end
                end else if (imem_resp && !stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem_rdata;
                    pc_d       = w_pc_plus4;
                end else if (imem_resp) begin
                    hold_d  = imem_rdata;
                    state_d = HOLD;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = FETCH;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = hold_q;
                    pc_d       = w_pc_plus4;
                    state_d    = FETCH;
                end
            end
            DISCARD: begin
                if (imem_resp) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC, side buffers and IF/ID register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            stale_q    <= 32'd0;
            hold_q     <= NOP_INSTR;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stale_q    <= stale_d;
            hold_q     <= hold_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_i_fetch
// Description : Self-checking bench for i_fetch. A memory model answers
//               requests with configurable latency; a monitor checks every
//               instruction ID accepts against the expected program flow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i_fetch;

    localparam logic [31:0] RESET_PC = 32'h4000_0060;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_resp = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    i_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_consumed = 0;

    // Scoreboard: redirect targets in issue order; each one starts a new
    // sequential instruction stream that ID must observe.
    logic [31:0] redir_q[$];
    logic [31:0] exp_pc = RESET_PC;

    // Memory model state
    int  min_lat = 0;
    int  max_lat = 0;
    bit  busy = 0;
    int  cnt = 0;
    int  lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: one request at a time, response lat cycles after the first
    // request cycle (lat==0 answers in the same cycle).
    task automatic mem_eval();
        if (!rst || !imem_read) begin
            busy      = 0;
            imem_resp = 1'b0;
        end else begin
            if (!busy) begin
                busy = 1;
                cnt  = 0;
                lat  = $urandom_range(max_lat, min_lat);
            end
            if (cnt == lat) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(imem_address);
                busy       = 0;
            end else begin
                imem_resp  = 1'b0;
                imem_rdata = $urandom;
                cnt++;
            end
        end
    endtask

    task automatic edge_then();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive stall/redirect, answer memory, wait for mid-cycle
    task automatic cyc(input logic s, input logic r, input logic [31:0] tgt);
        edge_then();
        stall       = s;
        redirect    = r;
        redirect_pc = tgt;
        if (r) redir_q.push_back(tgt);
        mem_eval();
        @(negedge clk);
    endtask

    // Monitor: protocol rules and in-order delivery of the expected stream
    logic        prev_ok = 0;
    logic        prev_read = 0;
    logic        prev_resp = 0;
    logic        prev_redir = 0;
    logic [31:0] prev_addr = 0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_pc  = RESET_PC;
            prev_ok = 0;
        end else begin
            if (prev_ok && prev_read && !prev_resp) begin
                check("req_held_read", {31'd0, imem_read}, 32'd1);
                check("req_held_addr", imem_address, prev_addr);
            end
            if (prev_ok && prev_redir)
                check("flush_after_redirect", {31'd0, if_valid}, 32'd0);
            if (if_valid && !stall) begin
                check("ifid_pc", if_pc, exp_pc);
                check("ifid_instr", if_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (redirect) begin
                if (redir_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL redirect_queue: got empty expected entry at %0t", $time);
                end else begin
                    exp_pc = redir_q.pop_front();
                end
            end
            prev_ok    = 1;
            prev_read  = imem_read;
            prev_resp  = imem_resp;
            prev_redir = redirect;
            prev_addr  = imem_address;
        end
    end

    logic [31:0] held_pc;
    logic [31:0] saved;
    logic [31:0] tmp;
    bit          found;
    bit          seen;
    bit          done;

    initial begin
        // ---- Reset values ----
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_imem_read", {31'd0, imem_read}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_imem_addr", imem_address, RESET_PC);

        // ---- Zero-wait memory streams one instruction per cycle ----
        min_lat = 0; max_lat = 0;
        edge_then();
        rst = 1'b1;
        mem_eval();
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b0, 1'b0, 32'd0);
            check("t1_addr", imem_address, RESET_PC + 32'(4 * (k - 1)));
            if (k >= 2) begin
                check("t1_valid", {31'd0, if_valid}, 32'd1);
                check("t1_if_pc", if_pc, RESET_PC + 32'(4 * (k - 2)));
            end
        end

        // ---- Three-cycle requests ----
        min_lat = 2; max_lat = 2;
        repeat (12) cyc(1'b0, 1'b0, 32'd0);

        // ---- Stall across a response: IF/ID frozen, no request in HOLD ----
        min_lat = 0; max_lat = 0;
        repeat (4) cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        check("t3_resp_in_stall", {31'd0, imem_resp}, 32'd1);
        held_pc = if_pc;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 32'd0);
            check("t3_hold_read", {31'd0, imem_read}, 32'd0);
            check("t3_hold_if_pc", if_pc, held_pc);
        end
        repeat (3) cyc(1'b0, 1'b0, 32'd0);

        // ---- Redirect with a request outstanding ----
        min_lat = 2; max_lat = 2;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            edge_then();
            stall = 1'b0;
            redirect = 1'b0;
            mem_eval();
            if (imem_read && !imem_resp) begin
                redirect    = 1'b1;
                redirect_pc = 32'h4000_0100;
                redir_q.push_back(redirect_pc);
                saved = imem_address;
                found = 1;
            end
            @(negedge clk);
        end
        check("t4_found_outstanding", {31'd0, found}, 32'd1);
        seen = 0; done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            cyc(1'b0, 1'b0, 32'd0);
            if (!seen) begin
                check("t4_stale_addr", imem_address, saved);
                check("t4_stale_read", {31'd0, imem_read}, 32'd1);
                check("t4_no_valid", {31'd0, if_valid}, 32'd0);
                if (imem_resp) seen = 1;
            end else begin
                check("t4_target_addr", imem_address, 32'h4000_0100);
                check("t4_no_valid2", {31'd0, if_valid}, 32'd0);
                done = 1;
            end
        end
        check("t4_completed", {31'd0, done}, 32'd1);

        // ---- Redirect + stall + response in the same cycle ----
        min_lat = 0; max_lat = 0;
        repeat (3) cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 32'h4000_0200);
        check("t5_resp_same_cycle", {31'd0, imem_resp}, 32'd1);
        cyc(1'b0, 1'b0, 32'd0);
        check("t5_target_addr", imem_address, 32'h4000_0200);
        check("t5_no_valid", {31'd0, if_valid}, 32'd0);

        // ---- PC wrap, then asynchronous reset mid-request ----
        repeat (2) cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'd0);
        check("t6_addr_top", imem_address, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'd0);
        check("t6_addr_wrap", imem_address, 32'h0000_0000);
        min_lat = 3; max_lat = 3;
        cyc(1'b0, 1'b0, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_read", {31'd0, imem_read}, 32'd0);
        check("t6_async_valid", {31'd0, if_valid}, 32'd0);
        check("t6_async_if_pc", if_pc, 32'd0);
        check("t6_async_instr", if_instr, NOP);
        check("t6_async_addr", imem_address, RESET_PC);
        edge_then();
        mem_eval();
        edge_then();
        rst = 1'b1;
        mem_eval();
        @(negedge clk);

        // ---- Randomised stall/redirect/latency traffic ----
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                min_lat = 0;
                max_lat = $urandom_range(3, 0);
            end
            edge_then();
            stall    = ($urandom_range(99, 0) < 25);
            redirect = ($urandom_range(99, 0) < 6);
            tmp = $urandom;
            if ($urandom_range(3, 0) == 0)
                redirect_pc = 32'hFFFF_FFF0 | {28'd0, tmp[1:0], 2'b00};
            else
                redirect_pc = {tmp[31:2], 2'b00};
            if (redirect) redir_q.push_back(redirect_pc);
            mem_eval();
            @(negedge clk);
        end
        repeat (10) cyc(1'b0, 1'b0, 32'd0);

        check("progress", {31'd0, n_consumed >= 300}, 32'd1);
        check("redirects_drained", 32'(redir_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
